// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and one-cycle bubble insertion.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_stall_i,
    input  logic [DATA_W-1:0] ID_RSdata_i,
    input  logic [DATA_W-1:0] ID_RTdata_i,
    input  logic [DATA_W-1:0] ID_imm_i,
    input  logic [4:0]        ID_RSaddr_i,
    input  logic [4:0]        ID_RTaddr_i,
    input  logic [4:0]        ID_RDaddr_i,
    input  logic              ID_RegWrite_i,
    input  logic              ID_MemtoReg_i,
    input  logic              ID_MemRead_i,
    input  logic              ID_MemWrite_i,
    input  logic              ID_ALUSrc_i,
    input  logic              ID_RegDst_i,
    input  logic [1:0]        ID_ALUOp_i,
    output logic [DATA_W-1:0] EX_RSdata_o,
    output logic [DATA_W-1:0] EX_RTdata_o,
    output logic [DATA_W-1:0] EX_imm_o,
    output logic [4:0]        EX_RSaddr_o,
    output logic [4:0]        EX_RTaddr_o,
    output logic [4:0]        EX_RDaddr_o,
    output logic              EX_RegWrite_o,
    output logic              EX_MemtoReg_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic              EX_ALUSrc_o,
    output logic              EX_RegDst_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic              EX_valid_o,
    output logic              hazard_o,
    output logic              pc_write_o,
    output logic              if_id_write_o
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt_o
`endif
);

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rs_addr;
        logic [REG_AW-1:0]  rt_addr;
        logic [REG_AW-1:0]  rd_addr;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } id_ex_t;

    id_ex_t id_pl;
    id_ex_t ex_d, ex_q;
    logic   valid_d, valid_q;
    logic   hazard;

    always_comb begin
        id_pl            = '0;
        id_pl.rs_data    = ID_RSdata_i;
        id_pl.rt_data    = ID_RTdata_i;
        id_pl.imm        = ID_imm_i;
        id_pl.rs_addr    = ID_RSaddr_i;
        id_pl.rt_addr    = ID_RTaddr_i;
        id_pl.rd_addr    = ID_RDaddr_i;
        id_pl.reg_write  = ID_RegWrite_i;
        id_pl.mem_to_reg = ID_MemtoReg_i;
        id_pl.mem_read   = ID_MemRead_i;
        id_pl.mem_write  = ID_MemWrite_i;
        id_pl.alu_src    = ID_ALUSrc_i;
        id_pl.reg_dst    = ID_RegDst_i;
        id_pl.alu_op     = ID_ALUOp_i;
    end

    // Load in EX whose destination is a source of the instruction in ID; $0 never hazards.
    always_comb begin
        hazard = ex_q.mem_read & valid_q & (ex_q.rt_addr != '0)
               & ((ex_q.rt_addr == ID_RSaddr_i) | (ex_q.rt_addr == ID_RTaddr_i));
    end

    // Per-cycle update priority: stall holds, hazard bubbles, otherwise load.
    always_comb begin
        ex_d    = ex_q;
        valid_d = valid_q;
        if (!mem_stall_i) begin
            if (hazard) begin
                ex_d    = '0;
                valid_d = 1'b0;
            end else begin
                ex_d    = id_pl;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    localparam int unsigned CNT_W = 32;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!mem_stall_i && hazard) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt_o = bubble_cnt_q;
`endif

    assign EX_RSdata_o   = ex_q.rs_data;
    assign EX_RTdata_o   = ex_q.rt_data;
    assign EX_imm_o      = ex_q.imm;
    assign EX_RSaddr_o   = ex_q.rs_addr;
    assign EX_RTaddr_o   = ex_q.rt_addr;
    assign EX_RDaddr_o   = ex_q.rd_addr;
    assign EX_RegWrite_o = ex_q.reg_write;
    assign EX_MemtoReg_o = ex_q.mem_to_reg;
    assign EX_MemRead_o  = ex_q.mem_read;
    assign EX_MemWrite_o = ex_q.mem_write;
    assign EX_ALUSrc_o   = ex_q.alu_src;
    assign EX_RegDst_o   = ex_q.reg_dst;
    assign EX_ALUOp_o    = ex_q.alu_op;
    assign EX_valid_o    = valid_q;

    assign hazard_o      = hazard;
    assign pc_write_o    = ~(hazard | mem_stall_i);
    assign if_id_write_o = ~(hazard | mem_stall_i);

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios followed by random traffic checked
// against an instruction-level model of the EX slot.
module tb_id_ex_pipe_reg;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              mem_stall_i = 1'b0;
    logic [DATA_W-1:0] id_rsd = '0, id_rtd = '0, id_imm = '0;
    logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0;
    logic [7:0]        id_ctl = '0; // {RegWrite,MemtoReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp}

    logic [DATA_W-1:0] ex_rsd, ex_rtd, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_rw, ex_m2r, ex_mr, ex_mw, ex_as, ex_rdst;
    logic [1:0]        ex_aop;
    logic              ex_valid, hazard_o, pc_write_o, if_id_write_o;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0]       bubble_cnt_o;
`endif

    id_ex_pipe_reg #(.DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .mem_stall_i(mem_stall_i),
        .ID_RSdata_i(id_rsd), .ID_RTdata_i(id_rtd), .ID_imm_i(id_imm),
        .ID_RSaddr_i(id_rs), .ID_RTaddr_i(id_rt), .ID_RDaddr_i(id_rd),
        .ID_RegWrite_i(id_ctl[7]), .ID_MemtoReg_i(id_ctl[6]), .ID_MemRead_i(id_ctl[5]),
        .ID_MemWrite_i(id_ctl[4]), .ID_ALUSrc_i(id_ctl[3]), .ID_RegDst_i(id_ctl[2]),
        .ID_ALUOp_i(id_ctl[1:0]),
        .EX_RSdata_o(ex_rsd), .EX_RTdata_o(ex_rtd), .EX_imm_o(ex_imm),
        .EX_RSaddr_o(ex_rs), .EX_RTaddr_o(ex_rt), .EX_RDaddr_o(ex_rd),
        .EX_RegWrite_o(ex_rw), .EX_MemtoReg_o(ex_m2r), .EX_MemRead_o(ex_mr),
        .EX_MemWrite_o(ex_mw), .EX_ALUSrc_o(ex_as), .EX_RegDst_o(ex_rdst),
        .EX_ALUOp_o(ex_aop), .EX_valid_o(ex_valid), .hazard_o(hazard_o),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Model of what instruction occupies EX
    typedef struct {
        logic        valid;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctl;
    } instr_t;

    instr_t      m;
    int unsigned m_cnt;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [127:0] model_vec();
        return 128'({m.valid, m.rsd, m.rtd, m.imm, m.rs, m.rt, m.rd, m.ctl});
    endfunction

    function automatic logic [127:0] dut_vec();
        return 128'({ex_valid, ex_rsd, ex_rtd, ex_imm, ex_rs, ex_rt, ex_rd,
                     ex_rw, ex_m2r, ex_mr, ex_mw, ex_as, ex_rdst, ex_aop});
    endfunction

    function automatic logic model_hazard();
        return m.valid && m.ctl[5] && (m.rt != 5'd0) && ((m.rt == id_rs) || (m.rt == id_rt));
    endfunction

    task automatic model_clear();
        m = '{valid: 1'b0, rsd: '0, rtd: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctl: '0};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [7:0] ctl, input logic stall);
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rsd = rsd; id_rtd = rtd; id_imm = imm;
        id_ctl = ctl; mem_stall_i = stall;
    endtask

    // Check combinational outputs, clock once, advance model, check registered state.
    task automatic step(input string tag);
        logic hz;
        hz = model_hazard();
        #1;
        chk({tag, ".hazard"}, 128'(hazard_o), 128'(hz));
        chk({tag, ".pc_write"}, 128'(pc_write_o), 128'(!(hz || mem_stall_i)));
        chk({tag, ".if_id_write"}, 128'(if_id_write_o), 128'(!(hz || mem_stall_i)));
        @(posedge clk);
        if (!rst_i) begin
            model_clear();
            m_cnt = 0;
        end else if (mem_stall_i) begin
            // instruction stays put
        end else if (hz) begin
            model_clear();
            m_cnt = m_cnt + 1;
        end else begin
            m = '{valid: 1'b1, rsd: id_rsd, rtd: id_rtd, imm: id_imm,
                  rs: id_rs, rt: id_rt, rd: id_rd, ctl: id_ctl};
        end
        #1;
        chk({tag, ".ex_regs"}, dut_vec(), model_vec());
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, ".bubble_cnt"}, 128'(bubble_cnt_o), 128'(m_cnt));
`endif
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        m_cnt = 0;
        drive(5'd7, 5'd9, 5'd11, 32'hDEAD, 32'hBEEF, 32'h1234, 8'hFF, 1'b0);
        #2 rst_i = 1'b0;
        #1;
        chk("reset_async", dut_vec(), 128'd0);
        step("reset");
        chk("reset_valid", 128'(ex_valid), 128'd0);
        rst_i = 1'b1;

        // plain load
        drive(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, 8'h80, 1'b0);
        step("plain_load");
        chk("plain_rsaddr", 128'(ex_rs), 128'd3);
        chk("plain_valid", 128'(ex_valid), 128'd1);

        // load-use: lw $8 then add using $8
        drive(5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 8'hE8, 1'b0);
        step("lw8");
        drive(5'd8, 5'd6, 5'd10, 32'h5, 32'h6, 32'h0, 8'h86, 1'b0);
        #1;
        chk("lu_hazard", 128'(hazard_o), 128'd1);
        chk("lu_pc_write", 128'(pc_write_o), 128'd0);
        step("lu_bubble");
        chk("lu_bubble_rd", 128'(ex_rd), 128'd0);
        chk("lu_bubble_valid", 128'(ex_valid), 128'd0);
        step("lu_add_loads");
        chk("lu_add_rd", 128'(ex_rd), 128'd10);

        // load into $0 never hazards
        drive(5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 8'hE8, 1'b0);
        step("lw0");
        drive(5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h0, 8'h86, 1'b0);
        step("lw0_use");
        chk("lw0_valid", 128'(ex_valid), 128'd1);

        // stall has priority over hazard
        drive(5'd2, 5'd9, 5'd0, 32'h0, 32'h0, 32'hC, 8'hE8, 1'b0);
        step("lw9");
        for (int i = 0; i < 3; i++) begin
            drive(5'd9, 5'd3, 5'd13, 32'h7, 32'h8, 32'h0, 8'h86, 1'b1);
            step("stall_hold");
        end
        chk("stall_rt", 128'(ex_rt), 128'd9);
        mem_stall_i = 1'b0;
        step("stall_release_bubble");
        step("stall_release_load");
        chk("stall_after_rd", 128'(ex_rd), 128'd13);

`ifdef ID_EX_BUBBLE_CNT_EN
        // counter wrap
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.bubble_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        drive(5'd2, 5'd14, 5'd0, 32'h0, 32'h0, 32'h0, 8'hE8, 1'b0);
        step("wrap_lw");
        drive(5'd14, 5'd1, 5'd3, 32'h0, 32'h0, 32'h0, 8'h80, 1'b0);
        step("wrap_bubble");
        chk("wrap_zero", 128'(bubble_cnt_o), 128'd0);
`endif

        // random traffic with small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, $urandom, 8'($urandom), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 49) == 0) begin
                rst_i = 1'b0;
                #1;
                chk("rand_async_reset", dut_vec(), 128'd0);
                model_clear();
                m_cnt = 0;
                step("rand_in_reset");
                rst_i = 1'b1;
            end else begin
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register with integrated load-use hazard detection, for the 5-stage pipeline. It captures decoded operands, register addresses and control bits from ID, and presents them to EX and the forwarding logic, which reads `EX_RSaddr_o`, `EX_RTaddr_o` and the EX-stage control bits. On a load-use hazard it inserts one bubble into EX and freezes PC and IF/ID. A global memory stall freezes the register.

## Interface
Parameters:
- `DATA_W`, 32, operand/immediate width.

Ports (reset is asynchronous, active-low):
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `mem_stall_i` in 1: global stall; hold all state.
- `ID_RSdata_i`, `ID_RTdata_i` in DATA_W: register file read data.
- `ID_imm_i` in DATA_W: sign-extended immediate.
- `ID_RSaddr_i`, `ID_RTaddr_i`, `ID_RDaddr_i` in 5: decoded register addresses.
- `ID_RegWrite_i`, `ID_MemtoReg_i`, `ID_MemRead_i`, `ID_MemWrite_i`, `ID_ALUSrc_i`, `ID_RegDst_i` in 1 each: control bits.
- `ID_ALUOp_i` in 2: ALU op class.
- `EX_*_o` out (same widths as the matching `ID_*_i`): registered copies of every input above, including `EX_RSaddr_o` and `EX_RTaddr_o`.
- `EX_valid_o` out 1: EX holds a real instruction, not a bubble.
- `hazard_o` out 1: load-use hazard detected this cycle.
- `pc_write_o` out 1: PC update enable.
- `if_id_write_o` out 1: IF/ID register update enable.
- `bubble_cnt_o` out 32: bubbles inserted. Exists only with `ID_EX_BUBBLE_CNT_EN`.

## Operation
- `hazard_o` is combinational. It is 1 when all of the following hold:
  - `EX_MemRead_o` is 1.
  - `EX_valid_o` is 1.
  - `EX_RTaddr_o` is not 0.
  - `EX_RTaddr_o` equals `ID_RSaddr_i` or `ID_RTaddr_i`.
- `pc_write_o` and `if_id_write_o` both equal `~(hazard_o | mem_stall_i)`.
- Register update on each rising edge, in priority order:
  1. `mem_stall_i` = 1: HOLD. All `EX_*_o` and `EX_valid_o` keep their values. No bubble is counted.
  2. `hazard_o` = 1: BUBBLE.
     - All control outputs, `EX_ALUOp_o`, all three address outputs, both data outputs and `EX_imm_o` load 0.
     - `EX_valid_o` loads 0.
     - The counter increments.
  3. Otherwise: LOAD. All `ID_*_i` are captured and `EX_valid_o` loads 1.
- Zeroed addresses in a bubble guarantee that downstream forwarding never matches on a bubble (address 0 never forwards).
- After a bubble, `EX_MemRead_o` = 0, so the same ID instruction cannot cause a second bubble. Load-use therefore costs exactly one stall cycle.
- Hazard during HOLD: `hazard_o` may be 1 but is not acted on. The bubble is inserted on the first edge with `mem_stall_i` = 0, provided the hazard still holds.
- The block keeps no state machine beyond the register contents; the LOAD/BUBBLE/HOLD behaviour is selected per cycle as above.

## Timing
- Latency: ID inputs appear on `EX_*_o` one cycle after a LOAD edge.
- `hazard_o`, `pc_write_o` and `if_id_write_o` are purely combinational from registered EX state, `ID_RSaddr_i`/`ID_RTaddr_i` and `mem_stall_i`. They carry no register delay.
- Reset:
  - Asserting `rst_i` = 0 immediately, without waiting for a clock edge, drives all `EX_*_o`, `EX_valid_o` and `bubble_cnt_o` to 0.
  - Consequently `hazard_o` = 0, and `pc_write_o`/`if_id_write_o` = `~mem_stall_i`.
  - Reset asserted mid-stall or mid-bubble discards the held instruction.
- Deassertion of `rst_i` is synchronous to `clk_i`. The first edge with `rst_i` = 1 performs a normal update.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - `bubble_cnt_o` exists as a 32-bit counter. It resets to 0 and increments by 1 on each BUBBLE edge.
  - It wraps from 0xFFFFFFFF to 0 and holds during HOLD.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: drive `rst_i` = 0 with non-zero ID inputs, then pulse `clk_i` -> all `EX_*_o` = 0, `EX_valid_o` = 0, `pc_write_o` = 1.
- Plain load: ID presents RS=3, RT=4, RD=5, RSdata=0x11, RegWrite=1; apply one edge -> EX outputs match, `EX_valid_o` = 1, `hazard_o` = 0.
- Load-use: EX holds `lw` (MemRead=1, RT=8); ID presents RS=8 -> `hazard_o` = 1 and `pc_write_o` = 0 that cycle.
  - Next edge: EX control outputs = 0, `EX_RDaddr_o` = 0, `EX_valid_o` = 0, counter = 1.
  - Following edge: the `add` loads normally.
- Load to $0: EX holds `lw` with RT=0; ID presents RS=0 -> `hazard_o` = 0 and no bubble.
- Stall priority: load-use condition present with `mem_stall_i` = 1 for 3 cycles -> EX contents unchanged and counter unchanged.
  - When the stall drops: exactly one bubble, counter +1.
- Counter wrap (`ID_EX_BUBBLE_CNT_EN` defined): force counter to 0xFFFFFFFF, then trigger one bubble -> `bubble_cnt_o` = 0.
